// File: rtl/mhd_stream_monitor.sv
// Streaming popcount(a^b) checker with running error statistics; 2-stage pipeline.
// Latency 2 edges from accept to out_valid; in_ready is combinational and stalls stage 1 while stage 2 is held.
module mhd_stream_monitor #(
   parameter int WIDTH = 8,
   parameter int MHD   = 1,
   parameter int CNT_W = 16,
   localparam int HD_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [HD_W-1:0]  out_hd,
   output logic             out_viol,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [HD_W-1:0]  max_hd,
   output logic             err_sticky
);

   localparam logic [31:0]      MHD_U   = 32'(MHD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             s2_vld_q, s2_vld_d;
   logic [HD_W-1:0]  hd_q, hd_d;
   logic             viol_q, viol_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
   logic [HD_W-1:0]  max_hd_q, max_hd_d;
   logic             err_sticky_q, err_sticky_d;

   logic            s2_load, s1_adv, consume;
   logic [HD_W-1:0] pop;

   always_comb begin
      s2_load = !s2_vld_q || out_ready;
      s1_adv  = s2_load || !s1_vld_q;
      consume = s2_vld_q && out_ready;

      s1_vld_d     = s1_vld_q;
      diff_d       = diff_q;
      s2_vld_d     = s2_vld_q;
      hd_d         = hd_q;
      viol_d       = viol_q;
      sample_cnt_d = sample_cnt_q;
      viol_cnt_d   = viol_cnt_q;
      max_hd_d     = max_hd_q;
      err_sticky_d = err_sticky_q;

      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + HD_W'(diff_q[i]);
      end

      if (s1_adv) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            diff_d = a ^ b;
         end
      end

      if (s2_load) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            hd_d   = pop;
            // With MHD >= WIDTH this compare can never be true.
            viol_d = 32'(pop) > MHD_U;
         end
      end

      // clear takes priority over a consume in the same cycle.
      if (clear) begin
         sample_cnt_d = '0;
         viol_cnt_d   = '0;
         max_hd_d     = '0;
         err_sticky_d = 1'b0;
      end else if (consume) begin
         if (sample_cnt_q != CNT_MAX) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
         end
         if (viol_q && (viol_cnt_q != CNT_MAX)) begin
            viol_cnt_d = viol_cnt_q + CNT_W'(1);
         end
         if (hd_q > max_hd_q) begin
            max_hd_d = hd_q;
         end
         err_sticky_d = err_sticky_q | viol_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q     <= 1'b0;
         diff_q       <= '0;
         s2_vld_q     <= 1'b0;
         hd_q         <= '0;
         viol_q       <= 1'b0;
         sample_cnt_q <= '0;
         viol_cnt_q   <= '0;
         max_hd_q     <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         s1_vld_q     <= s1_vld_d;
         diff_q       <= diff_d;
         s2_vld_q     <= s2_vld_d;
         hd_q         <= hd_d;
         viol_q       <= viol_d;
         sample_cnt_q <= sample_cnt_d;
         viol_cnt_q   <= viol_cnt_d;
         max_hd_q     <= max_hd_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign in_ready   = s1_adv;
   assign out_valid  = s2_vld_q;
   assign out_hd     = hd_q;
   assign out_viol   = viol_q;
   assign sample_cnt = sample_cnt_q;
   assign viol_cnt   = viol_cnt_q;
   assign max_hd     = max_hd_q;
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// Directed bench for mhd_stream_monitor: main instance (W=8, MHD=1) plus a CNT_W=4 instance for saturation.
module tb_mhd_stream_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_hd;
   logic        out_viol;
   logic [15:0] sample_cnt, viol_cnt;
   logic [3:0]  max_hd;
   logic        err_sticky;

   logic        s_clear, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_viol, s_err_sticky;
   logic [7:0]  s_a, s_b;
   logic [3:0]  s_out_hd, s_max_hd;
   logic [3:0]  s_sample_cnt, s_viol_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mhd_stream_monitor #(.WIDTH(8), .MHD(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .out_hd(out_hd), .out_viol(out_viol),
      .sample_cnt(sample_cnt), .viol_cnt(viol_cnt), .max_hd(max_hd), .err_sticky(err_sticky)
   );

   mhd_stream_monitor #(.WIDTH(8), .MHD(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .clear(s_clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_hd(s_out_hd), .out_viol(s_out_viol),
      .sample_cnt(s_sample_cnt), .viol_cnt(s_viol_cnt), .max_hd(s_max_hd), .err_sticky(s_err_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs at a negedge, advance through one posedge, return at the next negedge.
   task automatic cyc(input logic vld, input logic [7:0] av, input logic [7:0] bv,
                      input logic rdy, input logic clr);
      in_valid  = vld;
      a         = av;
      b         = bv;
      out_ready = rdy;
      clear     = clr;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; clear = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [7:0] pat [6];
   logic [3:0] got_q [$];
   int         idx;

   initial begin
      s_clear = 1'b0; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
      pat[0] = 8'h01; pat[1] = 8'h03; pat[2] = 8'h07; pat[3] = 8'h0F; pat[4] = 8'h1F; pat[5] = 8'h00;

      // Reset state
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_hd", 32'(out_hd), 32'd0);
      chk("rst_out_viol", 32'(out_viol), 32'd0);
      chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
      chk("rst_err_sticky", 32'(err_sticky), 32'd0);

      // Identical words: zero distance, two register stages to output
      cyc(1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0);
      chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_hd", 32'(out_hd), 32'd0);
      chk("t1_viol", 32'(out_viol), 32'd0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t1_sample_cnt", 32'(sample_cnt), 32'd1);

      // Back-to-back pairs at full throughput
      do_reset();
      cyc(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
      cyc(1'b1, 8'h01, 8'h03, 1'b1, 1'b0);
      chk("t2_hd0", 32'(out_hd), 32'd8);
      chk("t2_viol0", 32'(out_viol), 32'd1);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t2_valid1", 32'(out_valid), 32'd1);
      chk("t2_hd1", 32'(out_hd), 32'd1);
      chk("t2_viol1", 32'(out_viol), 32'd0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t2_sample_cnt", 32'(sample_cnt), 32'd2);
      chk("t2_viol_cnt", 32'(viol_cnt), 32'd1);
      chk("t2_max_hd", 32'(max_hd), 32'd8);
      chk("t2_err_sticky", 32'(err_sticky), 32'd1);
      chk("t2_drained", 32'(out_valid), 32'd0);

      // Backpressure: only two pairs fit while the output is held
      do_reset();
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; a = pat[idx]; b = 8'h00; out_ready = 1'b0;
         #1;
         if (in_ready) idx++;
         @(negedge clk);
      end
      #1;
      chk("t3_accepted_stalled", 32'(idx), 32'd2);
      chk("t3_in_ready_low", 32'(in_ready), 32'd0);
      chk("t3_held_valid", 32'(out_valid), 32'd1);
      chk("t3_held_hd", 32'(out_hd), 32'd1);
      @(negedge clk);
      chk("t3_still_held_hd", 32'(out_hd), 32'd1);
      got_q.delete();
      for (int c = 0; c < 30; c++) begin
         in_valid = (idx < 5); a = pat[idx]; b = 8'h00; out_ready = 1'b1;
         #1;
         if (in_valid && in_ready) idx++;
         if (out_valid) got_q.push_back(out_hd);
         @(negedge clk);
         if (got_q.size() >= 5 && idx >= 5) break;
      end
      in_valid = 1'b0;
      chk("t3_result_count", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got_q.size()) chk($sformatf("t3_order_%0d", i), 32'(got_q[i]), 32'(i + 1));
         else chk($sformatf("t3_missing_%0d", i), 32'd0, 32'(i + 1));
      end
      chk("t3_sample_cnt", 32'(sample_cnt), 32'd5);
      chk("t3_viol_cnt", 32'(viol_cnt), 32'd4);
      chk("t3_max_hd", 32'(max_hd), 32'd5);

      // Saturation on the CNT_W=4 instance
      for (int c = 0; c < 20; c++) begin
         s_in_valid = 1'b1; s_a = 8'hFF; s_b = 8'h00;
         @(negedge clk);
         if (c == 16) chk("t4_sample_at_15", 32'(s_sample_cnt), 32'd15);
      end
      s_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_sat_sample_cnt", 32'(s_sample_cnt), 32'd15);
      chk("t4_sat_viol_cnt", 32'(s_viol_cnt), 32'd15);
      chk("t4_sat_max_hd", 32'(s_max_hd), 32'd8);

      // clear in the same cycle as a violating consume
      do_reset();
      cyc(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t5_pre_sticky", 32'(err_sticky), 32'd1);
      cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'hF0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      chk("t5_clr_sample", 32'(sample_cnt), 32'd0);
      chk("t5_clr_viol", 32'(viol_cnt), 32'd0);
      chk("t5_clr_max", 32'(max_hd), 32'd0);
      chk("t5_clr_sticky", 32'(err_sticky), 32'd0);
      chk("t5_pipe_kept_hd", 32'(out_hd), 32'd4);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("t5_post_viol", 32'(viol_cnt), 32'd1);
      chk("t5_post_sample", 32'(sample_cnt), 32'd1);
      chk("t5_post_sticky", 32'(err_sticky), 32'd1);
      chk("t5_post_max", 32'(max_hd), 32'd4);

      // Asynchronous reset with two pairs in flight
      cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
      in_valid = 1'b0;
      chk("t6_in_flight", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(out_valid), 32'd0);
      chk("t6_async_sample", 32'(sample_cnt), 32'd0);
      chk("t6_async_sticky", 32'(err_sticky), 32'd0);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
         chk($sformatf("t6_no_stale_%0d", c), 32'(out_valid), 32'd0);
      end
      chk("t6_sample_after", 32'(sample_cnt), 32'd0);
      chk("t6_in_ready_after", 32'(in_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
